// File: rtl/capture_ctrl.sv
// capture_ctrl: run-control sequencer for the logic-analyzer capture path
// Define CAPTURE_CTRL_EXT_TRIG_EN to add the two-flop synchronized external trigger ext_trg_i.
module capture_ctrl #(
  parameter int MEM_DEPTH = 4096,
  parameter int CNT_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_in,
  input  logic                         cfg_stb_i,
  input  logic [3:0]                   cfg_en_i,
  input  logic                         cnt_stb_i,
  input  logic [CNT_W-1:0]             read_cnt_i,
  input  logic [CNT_W-1:0]             delay_cnt_i,
  input  logic                         arm_i,
  input  logic                         abort_i,
  input  logic                         trg_i,
`ifdef CAPTURE_CTRL_EXT_TRIG_EN
  input  logic                         ext_trg_i,
`endif
  input  logic                         smpl_stb_i,
  input  logic                         wr_stb_i,
  output logic                         cache_cfg_stb_o,
  output logic [3:0]                   cache_cfg_o,
  output logic                         cache_stb_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  output logic                         tx_stb_o,
  input  logic                         tx_busy_i,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, RD_REQ, RD_WAIT} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CNT_W-1:0] read_cnt, delay_cnt, post_cnt, remain, post_nxt, remain_nxt;
  logic tx_pend, trig, cap, we, done_nxt, cfg_ok;
`ifdef CAPTURE_CTRL_EXT_TRIG_EN
  logic [2:0] ext_q;
  assign trig = trg_i | (ext_q[1] & ~ext_q[2]);
`else
  assign trig = trg_i;
`endif
  assign cap = (state == ARMED || state == DELAY) && !abort_i;
  // a zero post-trigger window must not write past the trigger point
  assign we = cap && wr_stb_i && !(state == DELAY && delay_cnt == '0);
  assign cache_stb_o = cap && smpl_stb_i;
  assign mem_we_o = we;
  assign mem_addr_o = (state == RD_REQ || state == RD_WAIT) ? rd_ptr : wr_ptr;
  assign tx_stb_o = tx_pend && !abort_i;
  assign busy_o = state != IDLE;
  assign wr_nxt = wr_ptr + AW'(we);
  assign cfg_ok = state == IDLE && cfg_stb_i && cfg_en_i != 4'h0;
  always_comb begin
    state_nxt = state;
    post_nxt = post_cnt;
    remain_nxt = remain;
    rd_nxt = rd_ptr;
    done_nxt = 1'b0;
    if (abort_i) begin
      state_nxt = IDLE;
      post_nxt = '0;
      remain_nxt = '0;
    end else begin
      case (state)
        IDLE: state_nxt = arm_i ? ARMED : IDLE;
        ARMED: if (trig) begin
          state_nxt = DELAY;
          post_nxt = '0;
        end
        DELAY: begin
          post_nxt = post_cnt + CNT_W'(we);
          if (post_nxt == delay_cnt) begin
            state_nxt = (read_cnt == '0) ? IDLE : RD_REQ;
            done_nxt = read_cnt == '0;
            rd_nxt = wr_nxt - AW'(read_cnt);
            remain_nxt = read_cnt;
          end
        end
        RD_REQ: state_nxt = RD_WAIT;
        RD_WAIT: if (!tx_pend && !tx_busy_i) begin
          remain_nxt = remain - 1'b1;
          rd_nxt = rd_ptr + 1'b1;
          state_nxt = (remain_nxt == '0) ? IDLE : RD_REQ;
          done_nxt = remain_nxt == '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      read_cnt <= '0;
      delay_cnt <= '0;
      post_cnt <= '0;
      remain <= '0;
      tx_pend <= 1'b0;
      done_o <= 1'b0;
      cache_cfg_o <= 4'hF;
      cache_cfg_stb_o <= 1'b0;
`ifdef CAPTURE_CTRL_EXT_TRIG_EN
      ext_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      post_cnt <= post_nxt;
      remain <= remain_nxt;
      tx_pend <= state == RD_REQ && !abort_i;
      done_o <= done_nxt;
      cache_cfg_stb_o <= cfg_ok;
      if (cfg_ok) cache_cfg_o <= cfg_en_i;
      if (state == IDLE && cnt_stb_i) begin
        read_cnt <= (32'(read_cnt_i) > MEM_DEPTH) ? CNT_W'(MEM_DEPTH) : read_cnt_i;
        delay_cnt <= delay_cnt_i;
      end
`ifdef CAPTURE_CTRL_EXT_TRIG_EN
      ext_q <= {ext_q[1:0], ext_trg_i};
`endif
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed and randomized checks of capture_ctrl against a queue-based reference model
module tb_capture_ctrl;
  localparam int D = 16;
  logic clk = 1'b0, rst_in = 1'b0;
  logic cfg_stb_i = 0, cnt_stb_i = 0, arm_i = 0, abort_i = 0, trg_i = 0;
  logic smpl_stb_i = 0, wr_stb_i = 0, tx_busy_i = 0;
  logic [3:0] cfg_en_i = 0;
  logic [15:0] read_cnt_i = 0, delay_cnt_i = 0;
  logic cache_cfg_stb_o, cache_stb_o, mem_we_o, tx_stb_o, busy_o, done_o;
  logic [3:0] cache_cfg_o, mem_addr_o;
`ifdef CAPTURE_CTRL_EXT_TRIG_EN
  logic ext_trg_i = 1'b0;
`endif
  capture_ctrl #(.MEM_DEPTH(D), .CNT_W(16)) dut (
    .clk_i(clk), .rst_in(rst_in), .cfg_stb_i(cfg_stb_i), .cfg_en_i(cfg_en_i),
    .cnt_stb_i(cnt_stb_i), .read_cnt_i(read_cnt_i), .delay_cnt_i(delay_cnt_i),
    .arm_i(arm_i), .abort_i(abort_i), .trg_i(trg_i),
`ifdef CAPTURE_CTRL_EXT_TRIG_EN
    .ext_trg_i(ext_trg_i),
`endif
    .smpl_stb_i(smpl_stb_i), .wr_stb_i(wr_stb_i), .cache_cfg_stb_o(cache_cfg_stb_o),
    .cache_cfg_o(cache_cfg_o), .cache_stb_o(cache_stb_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .tx_stb_o(tx_stb_o), .tx_busy_i(tx_busy_i),
    .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, done_cnt = 0;
  int txlog[$];
  // reference model: phase 0 idle, 1 armed, 2 post-trigger, 3 readout
  int ph, wr, rc, dc, post, step;
  logic [3:0] mask;
  bit mcs, mdone;
  int q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_cap();
    return (ph == 1 || ph == 2) && !abort_i;
  endfunction

  function automatic bit m_we();
    return m_cap() && wr_stb_i && !(ph == 2 && dc == 0);
  endfunction

  task automatic m_reset();
    ph = 0; wr = 0; rc = 0; dc = 0; post = 0; step = 0;
    mask = 4'hF; mcs = 0; mdone = 0;
    q.delete();
  endtask

  task automatic m_update();
    bit we, idle;
    we = m_we();
    idle = ph == 0;
    mdone = 0;
    mcs = idle && cfg_stb_i && cfg_en_i != 0;
    if (mcs) mask = cfg_en_i;
    if (we) wr = (wr + 1) % D;
    if (abort_i) begin
      ph = 0; post = 0; q.delete();
    end else if (ph == 0) begin
      if (arm_i) ph = 1;
    end else if (ph == 1) begin
      if (trg_i) begin ph = 2; post = 0; end
    end else if (ph == 2) begin
      post += int'(we);
      if (post == dc) begin
        if (rc == 0) begin
          ph = 0; mdone = 1;
        end else begin
          ph = 3; step = 0;
          for (int i = 0; i < rc; i++) q.push_back((wr + D - rc + i) % D);
        end
      end
    end else begin
      if (step < 2) step++;
      else if (!tx_busy_i) begin
        void'(q.pop_front());
        if (q.size() == 0) begin ph = 0; mdone = 1; end
        else step = 0;
      end
    end
    if (idle && cnt_stb_i) begin
      rc = (int'(read_cnt_i) > D) ? D : int'(read_cnt_i);
      dc = int'(delay_cnt_i);
    end
  endtask

  task automatic m_compare();
    chk("cache_stb", cache_stb_o, m_cap() && smpl_stb_i);
    chk("mem_we", mem_we_o, m_we());
    if (ph != 0) chk("mem_addr", mem_addr_o, (ph == 3) ? q[0] : wr);
    chk("tx_stb", tx_stb_o, ph == 3 && step == 1 && !abort_i);
    chk("busy", busy_o, ph != 0);
    chk("done", done_o, mdone);
    chk("cfg_stb", cache_cfg_stb_o, mcs);
    chk("cfg_mask", cache_cfg_o, mask);
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_in) m_reset();
      m_compare();
      if (rst_in && tx_stb_o) txlog.push_back(int'(mem_addr_o));
      if (rst_in && done_o) done_cnt++;
      @(posedge clk or negedge rst_in);
      if (!rst_in) m_reset();
      else m_update();
    end
  end

  int exp_b[16] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3};
  int d0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_in = 1;
    #1;
    chk("rst_mask", cache_cfg_o, 4'hF);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_strobes", {cache_cfg_stb_o, cache_stb_o, mem_we_o, tx_stb_o, done_o}, 0);
    // configuration in IDLE, rejected zero mask, ignored in ARMED
    cfg_stb_i = 1; cfg_en_i = 4'b0101; tick(); cfg_stb_i = 0; cfg_en_i = 0;
    chk("cfg_pulse", cache_cfg_stb_o, 1);
    chk("cfg_value", cache_cfg_o, 4'b0101);
    tick(); chk("cfg_one_cycle", cache_cfg_stb_o, 0);
    cfg_stb_i = 1; tick(); cfg_stb_i = 0;
    chk("cfg_zero_stb", cache_cfg_stb_o, 0);
    chk("cfg_zero_keep", cache_cfg_o, 4'b0101);
    cnt_stb_i = 1; read_cnt_i = 5; delay_cnt_i = 3; tick(); cnt_stb_i = 0;
    arm_i = 1; tick(); arm_i = 0;
    chk("armed_busy", busy_o, 1);
    cfg_stb_i = 1; cfg_en_i = 4'b0011; tick(); cfg_stb_i = 0; cfg_en_i = 0;
    chk("cfg_armed_stb", cache_cfg_stb_o, 0);
    chk("cfg_armed_keep", cache_cfg_o, 4'b0101);
    // 10 pre-trigger + 3 post-trigger words, readout of the last 5
    wr_stb_i = 1; smpl_stb_i = 1; #1;
    chk("cache_gate", cache_stb_o, 1);
    repeat (10) tick();
    wr_stb_i = 0; smpl_stb_i = 0; trg_i = 1; tick(); trg_i = 0;
    wr_stb_i = 1; repeat (3) tick(); wr_stb_i = 0;
    chk("rd_first_addr", mem_addr_o, 8);
    chk("rd_no_we", mem_we_o, 0);
    tick();
    chk("tx_first", tx_stb_o, 1);
    tx_busy_i = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("tx_hold", tx_stb_o, 0);
      chk("rd_hold_addr", mem_addr_o, 8);
    end
    tx_busy_i = 0;
    for (int i = 0; i < 100 && !done_o; i++) tick();
    chk("a_done", done_o, 1);
    chk("a_busy_end", busy_o, 0);
    chk("a_tx_count", txlog.size(), 5);
    for (int i = 0; i < 5 && i < txlog.size(); i++) chk("a_tx_addr", txlog[i], 8 + i);
    tick();
    txlog.delete();
    // zero delay window, then reset in the middle of readout
    cnt_stb_i = 1; read_cnt_i = 3; delay_cnt_i = 0; tick(); cnt_stb_i = 0;
    arm_i = 1; tick(); arm_i = 0;
    trg_i = 1; tick(); trg_i = 0;
    wr_stb_i = 1; #1;
    chk("delay0_no_we", mem_we_o, 0);
    tick(); wr_stb_i = 0;
    chk("delay0_addr", mem_addr_o, 10);
    tick();
    chk("c_tx", tx_stb_o, 1);
    chk("c_tx_addr", mem_addr_o, 10);
    d0 = done_cnt;
    rst_in = 0; #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_tx", tx_stb_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_mask", cache_cfg_o, 4'hF);
    chk("mid_rst_done", done_o, 0);
    repeat (3) tick();
    rst_in = 1;
    repeat (3) tick();
    chk("mid_rst_no_done", done_cnt, d0);
    txlog.delete();
    // ring wrap with clamped read count
    cnt_stb_i = 1; read_cnt_i = 40; delay_cnt_i = 2; tick(); cnt_stb_i = 0;
    arm_i = 1; tick(); arm_i = 0;
    wr_stb_i = 1; repeat (18) tick(); wr_stb_i = 0;
    trg_i = 1; tick(); trg_i = 0;
    wr_stb_i = 1; repeat (2) tick(); wr_stb_i = 0;
    for (int i = 0; i < 300 && !done_o; i++) tick();
    chk("b_done", done_o, 1);
    chk("b_tx_count", txlog.size(), 16);
    for (int i = 0; i < 16 && i < txlog.size(); i++) chk("b_tx_addr", txlog[i], exp_b[i]);
    tick();
    // abort beats trigger while armed
    d0 = done_cnt;
    arm_i = 1; tick(); arm_i = 0;
    abort_i = 1; trg_i = 1; smpl_stb_i = 1; #1;
    chk("abort_cache_stb", cache_stb_o, 0);
    tick(); abort_i = 0; trg_i = 0; smpl_stb_i = 0;
    chk("abort_idle", busy_o, 0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt, d0);
    for (int c = 0; c < 4000; c++) begin
      arm_i = $urandom_range(0, 9) == 0;
      abort_i = $urandom_range(0, 149) == 0;
      trg_i = $urandom_range(0, 24) == 0;
      wr_stb_i = $urandom_range(0, 1) == 1;
      smpl_stb_i = $urandom_range(0, 1) == 1;
      tx_busy_i = $urandom_range(0, 2) == 0;
      cfg_stb_i = $urandom_range(0, 19) == 0;
      cfg_en_i = 4'($urandom_range(0, 15));
      cnt_stb_i = $urandom_range(0, 9) == 0;
      read_cnt_i = 16'($urandom_range(0, 40));
      delay_cnt_i = 16'($urandom_range(0, 8));
      tick();
    end
    {arm_i, abort_i, trg_i, wr_stb_i, smpl_stb_i, tx_busy_i, cfg_stb_i, cnt_stb_i} = '0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Run-control sequencer for the logic-analyzer capture path.
- Accepts host commands (configure, arm, abort) and forwards the channel-enable mask to the byte-packing cache.
- Gates sample strobes into the cache, tracks the sample-memory write pointer, and counts post-trigger words.
- Streams the captured window out to the transmitter word by word.

Parameters:
- MEM_DEPTH, 4096, sample memory depth in 32-bit words; power of two.
- CNT_W, 16, width of the read and delay count registers.

Ports:
- clk_i  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- cfg_stb_i  in  1  channel mask at cfg_en_i is valid.
- cfg_en_i  in  4  active input byte groups.
- cnt_stb_i  in  1  read_cnt_i and delay_cnt_i are valid.
- read_cnt_i  in  CNT_W  words to return on readout.
- delay_cnt_i  in  CNT_W  words to capture after the trigger.
- arm_i  in  1  start capture (pulse).
- abort_i  in  1  cancel any operation (pulse).
- trg_i  in  1  trigger hit from the trigger unit.
- smpl_stb_i  in  1  sampler has a new sample.
- wr_stb_i  in  1  cache emitted a packed word (cache stb_o).
- cache_cfg_stb_o  out  1  configuration strobe to the cache.
- cache_cfg_o  out  4  channel mask to the cache.
- cache_stb_o  out  1  gated sample strobe to the cache.
- mem_we_o  out  1  sample memory write enable.
- mem_addr_o  out  log2(MEM_DEPTH)  memory write/read address.
- tx_stb_o  out  1  memory read data is valid for the transmitter.
- tx_busy_i  in  1  transmitter is busy.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse at the end of readout.

Behaviour:
- Reset values:
  - All outputs 0, except cache_cfg_o = 4'hF.
  - State IDLE; wr_ptr = 0; registered read_cnt = delay_cnt = 0.
  - Reset mid-operation aborts immediately and produces no done_o.
- States: IDLE, ARMED, DELAY, READOUT, with sub-phases RD_REQ and RD_WAIT inside READOUT.
- Configuration (IDLE only; ignored in all other states):
  - cfg_stb_i with cfg_en_i != 0 registers the mask. One cycle later, cache_cfg_o updates and cache_cfg_stb_o pulses for one cycle.
  - cfg_en_i == 0 is rejected and the previous mask is kept.
  - cnt_stb_i latches both count inputs. read_cnt is clamped to MEM_DEPTH.
- IDLE: arm_i goes to ARMED next cycle; wr_ptr is not cleared.
- cache_stb_o = smpl_stb_i in ARMED or DELAY, otherwise 0. Combinational, 0 cycles latency.
- Memory writes (ARMED/DELAY):
  - mem_we_o = wr_stb_i; mem_addr_o = wr_ptr.
  - wr_ptr increments on each wr_stb_i and wraps modulo MEM_DEPTH; the pre-trigger history is a ring.
- ARMED: trg_i goes to DELAY; the post-trigger counter is cleared.
- DELAY:
  - The post-trigger counter increments per wr_stb_i.
  - When counter + wr_stb_i reaches delay_cnt, the next state is READOUT, after that write completes.
  - delay_cnt == 0 goes to READOUT on the next cycle with no further writes.
  - A trg_i asserted while in DELAY is ignored.
- READOUT:
  - rd_ptr starts at (wr_ptr - read_cnt) mod MEM_DEPTH; remaining = read_cnt.
  - RD_REQ: mem_addr_o = rd_ptr with we = 0; go to RD_WAIT.
  - RD_WAIT: one cycle later tx_stb_o pulses for one cycle (memory read latency 1). Hold until tx_busy_i == 0, then rd_ptr++ (wraps) and remaining--.
  - remaining == 0 goes to IDLE with done_o pulsed in the same cycle.
  - read_cnt == 0 skips directly to IDLE with a done_o pulse.
- abort_i:
  - From any state, go to IDLE next cycle; clear the counters; no done_o; tx_stb_o and cache_stb_o drop immediately.
  - Priority: abort_i over trg_i over arm_i.
- busy_o = (state != IDLE), registered together with the state.

Optional Feature:
- Macro: CAPTURE_CTRL_EXT_TRIG_EN.
- Defined:
  - Adds input ext_trg_i (1 bit, asynchronous).
  - It is synchronized through two flip-flops; its rising edge is ORed with trg_i.
  - Total latency is 3 cycles from the pin to the ARMED→DELAY transition.
- Undefined: no port exists and only trg_i triggers.

Test Plan:
- Reset release → cache_cfg_o = 4'hF; busy_o = 0; mem_addr_o = 0; no strobes.
- cfg_stb_i with cfg_en_i = 4'b0101 in IDLE → cache_cfg_stb_o pulses 1 cycle later with cache_cfg_o = 4'b0101. cfg_en_i = 0 → no strobe, mask unchanged. The same cfg issued in ARMED → ignored.
- delay_cnt = 3, read_cnt = 5, arm, 10 wr_stb_i, trg_i, 3 wr_stb_i → wr_ptr = 13. Readout addresses are 8, 9, 10, 11, 12; 5 tx_stb_o pulses; then done_o.
- MEM_DEPTH = 16, 20 writes, read_cnt = 16 → readout addresses 4..15 then 0..3. read_cnt = 40 → clamped to 16.
- tx_busy_i held high for 7 cycles after a tx_stb_o → rd_ptr stays unchanged and no new tx_stb_o is issued until busy drops.
- abort_i and trg_i in the same cycle while ARMED → IDLE next cycle with no done_o. rst_in asserted during READOUT → outputs reset immediately.
